// File: rtl/act_buf_pkg.sv
// Shared types and width helpers for the activation row buffer.
// FSM encoding, derived-width functions and a flag popcount.
package act_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SER,
      ST_PAR
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int occ_w(input int d);
      return $clog2(d) + 1;
   endfunction

   function automatic int unsigned popcount(input logic [255:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 256; i++)
         c += 32'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/act_row_buffer_if.sv
// Write/drain bundle of the activation row buffer.
// ACT_ROW_BUFFER_REPLAY_EN adds the rd_replay request.
interface act_row_buffer_if
   import act_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_COL    = 16,
   parameter int DEPTH      = 4
);
   localparam int IDX_W = idx_w(NUM_COL);
   localparam int OCC_W = occ_w(DEPTH);
   localparam int RW    = NUM_COL * DATA_WIDTH;

   logic                  mode;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [NUM_COL-1:0]    wr_flag;
   logic [RW-1:0]         wr_data;
   logic                  rd_start;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_serial;
   logic [IDX_W-1:0]      out_index;
   logic                  out_last;
   logic [RW-1:0]         out_parallel;
   logic [IDX_W:0]        row_val_num;
   logic                  row_done;
   logic [OCC_W-1:0]      occupancy;
   logic                  empty;
`ifdef ACT_ROW_BUFFER_REPLAY_EN
   logic                  rd_replay;

   modport master (
      output mode, wr_valid, wr_flag, wr_data, rd_start, out_ready,
      output rd_replay,
      input  wr_ready, out_valid, out_serial, out_index, out_last,
      input  out_parallel, row_val_num, row_done, occupancy, empty
   );

   modport slave (
      input  mode, wr_valid, wr_flag, wr_data, rd_start, out_ready,
      input  rd_replay,
      output wr_ready, out_valid, out_serial, out_index, out_last,
      output out_parallel, row_val_num, row_done, occupancy, empty
   );
`else
   modport master (
      output mode, wr_valid, wr_flag, wr_data, rd_start, out_ready,
      input  wr_ready, out_valid, out_serial, out_index, out_last,
      input  out_parallel, row_val_num, row_done, occupancy, empty
   );

   modport slave (
      input  mode, wr_valid, wr_flag, wr_data, rd_start, out_ready,
      output wr_ready, out_valid, out_serial, out_index, out_last,
      output out_parallel, row_val_num, row_done, occupancy, empty
   );
`endif

endinterface

// File: rtl/lsb_index_enc.sv
// Lowest-set-bit encoder: index of the lowest 1 in i_vec,
// plus a flag telling whether any bit is set.
module lsb_index_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      // Scan downwards so the lowest set bit wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = W'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/act_row_buffer.sv
// Row FIFO of activations drained serially (nonzero only) or in parallel.
// ACT_ROW_BUFFER_REPLAY_EN: final beat with rd_replay re-runs the row.
module act_row_buffer
   import act_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_COL    = 16,
   parameter int DEPTH      = 4
) (
   input logic              clk,
   input logic              reset,
   act_row_buffer_if.slave  bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = idx_w(NUM_COL);
   localparam int OCC_W = occ_w(DEPTH);
   localparam int VW    = IDX_W + 1;
   localparam int RW    = NUM_COL * DATA_WIDTH;

   logic [RW-1:0]         r_mem  [DEPTH];
   logic [NUM_COL-1:0]    r_fmem [DEPTH];
   logic [AW:0]           r_wptr;
   logic [AW:0]           r_rptr;
   logic [OCC_W-1:0]      r_occ;
   state_t                r_state;
   logic [RW-1:0]         r_work;
   logic [NUM_COL-1:0]    r_flag_l;
   logic [NUM_COL-1:0]    r_mask;
   logic                  r_mode;
   logic [IDX_W:0]        r_val_num;
   logic                  r_done;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;
   logic                  w_hs;
   logic                  w_last_ser;
   logic                  w_fin;
   logic                  w_replay;
   logic                  w_is_ser;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_any;
   logic [NUM_COL-1:0]    w_head_flag;
   logic [RW-1:0]         w_head_data;
   logic [DATA_WIDTH-1:0] w_ser;
   logic [RW-1:0]         w_par;

   lsb_index_enc #(
      .N (NUM_COL),
      .W (IDX_W)
   ) u_enc (
      .i_vec (r_mask),
      .o_idx (w_idx),
      .o_any (w_any)
   );

`ifdef ACT_ROW_BUFFER_REPLAY_EN
   assign w_replay = bus.rd_replay;
`else
   assign w_replay = 1'b0;
`endif

   assign w_full = (r_wptr[AW-1:0] == r_rptr[AW-1:0])
                && (r_wptr[AW] != r_rptr[AW]);
   assign w_empty     = (r_occ == '0);
   assign w_push      = bus.wr_valid && !w_full;
   assign w_head_flag = r_fmem[r_rptr[AW-1:0]];
   assign w_head_data = r_mem[r_rptr[AW-1:0]];
   assign w_is_ser    = (r_state == ST_SER);
   assign w_valid     = w_is_ser || (r_state == ST_PAR);
   assign w_hs        = w_valid && bus.out_ready;
   assign w_last_ser  = (r_mask & (r_mask - NUM_COL'(1))) == '0;
   assign w_fin       = w_hs && (!w_is_ser || w_last_ser);
   // An all-zero serial row retires straight out of LOAD.
   assign w_pop = (w_fin && !w_replay)
               || ((r_state == ST_LOAD) && !bus.mode
                   && (w_head_flag == '0));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]]  <= bus.wr_data;
         r_fmem[r_wptr[AW-1:0]] <= bus.wr_flag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_state   <= ST_IDLE;
         r_work    <= '0;
         r_flag_l  <= '0;
         r_mask    <= '0;
         r_mode    <= 1'b0;
         r_val_num <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_push)
            r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)
            r_rptr <= r_rptr + (AW+1)'(1);
         if (w_push && !w_pop)
            r_occ <= r_occ + OCC_W'(1);
         else if (!w_push && w_pop)
            r_occ <= r_occ - OCC_W'(1);
         unique case (r_state)
            ST_IDLE: begin
               if (bus.rd_start && !w_empty)
                  r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_work    <= w_head_data;
               r_flag_l  <= w_head_flag;
               r_mask    <= w_head_flag;
               r_mode    <= bus.mode;
               r_val_num <= VW'(popcount(256'(w_head_flag)));
               if (bus.mode) begin
                  r_state <= ST_PAR;
               end else if (w_head_flag == '0) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_SER;
               end
            end
            ST_SER: begin
               if (w_hs) begin
                  if (!w_last_ser) begin
                     r_mask <= r_mask & (r_mask - NUM_COL'(1));
                  end else if (w_replay) begin
                     r_mask <= r_flag_l;
                  end else begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_PAR: begin
               if (w_hs && !w_replay) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_ser = '0;
      w_par = '0;
      for (int i = 0; i < NUM_COL; i++) begin
         if (w_is_ser && w_any && (IDX_W'(i) == w_idx))
            w_ser = r_work[i*DATA_WIDTH +: DATA_WIDTH];
         if (w_valid && r_mode && r_flag_l[i])
            w_par[i*DATA_WIDTH +: DATA_WIDTH] =
               r_work[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.wr_ready     = !w_full;
   assign bus.out_valid    = w_valid;
   assign bus.out_serial   = w_ser;
   assign bus.out_index    = (w_is_ser && w_any) ? w_idx : '0;
   assign bus.out_last     = (r_state == ST_PAR) || (w_is_ser && w_last_ser);
   assign bus.out_parallel = w_par;
   assign bus.row_val_num  = r_val_num;
   assign bus.row_done     = r_done;
   assign bus.occupancy    = r_occ;
   assign bus.empty        = w_empty;

endmodule

// File: doc/act_row_buffer.md
Name: act_row_buffer

Overview:
Parametrised successor to the per-row activation store in the PE memory controller. Buffers DEPTH rows of NUM_COL activations, each with a NUM_COL-bit nonzero flag, in a row FIFO. Drains the head row either serially (nonzero entries only, with column index) or in parallel (full row, zero-masked by flag), under a valid/ready handshake. Sits between the global-buffer write port and the PE array input.

Parameters:
DATA_WIDTH, 8, bits per activation
NUM_COL, 16, activations per row (>=2)
DEPTH, 4, row FIFO depth (power of two, >=2)
IDX_W, $clog2(NUM_COL), column-index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
mode  in  1  0 = serial drain, 1 = parallel drain; sampled in LOAD only
wr_valid  in  1  write row offered
wr_ready  out  1  = !full
wr_flag  in  NUM_COL  nonzero bitmap of row
wr_data  in  NUM_COL*DATA_WIDTH  row data, column 0 in LSBs
rd_start  in  1  begin draining head row
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_serial  out  DATA_WIDTH  serial activation
out_index  out  IDX_W  column of out_serial
out_last  out  1  final beat of row
out_parallel  out  NUM_COL*DATA_WIDTH  masked row (parallel mode)
row_val_num  out  IDX_W+1  popcount of loaded row flag
row_done  out  1  one-cycle pulse on row pop
occupancy  out  $clog2(DEPTH)+1  rows stored
empty  out  1  occupancy==0

Behaviour:
- Reset (reset=0, asynchronous): pointers, occupancy, working registers, FSM -> IDLE; all outputs 0 except empty=1, wr_ready=1.
- FIFO: pointers carry an extra wrap bit; full when addresses are equal and wrap bits differ. Write on wr_valid&&wr_ready. Occupancy is updated on the same edge; simultaneous push and pop leave it unchanged.
- FSM: IDLE, LOAD, SER, PAR.
  - IDLE: rd_start&&!empty -> LOAD. rd_start is ignored when empty or when not in IDLE.
  - LOAD (1 cycle): latch head data/flag into working registers, latch mode, set row_val_num. Next state: mode=1 -> PAR; flag==0 -> pop, row_done, IDLE (no beat); else SER.
  - SER: out_valid=1; out_index = lowest set bit of working mask; out_serial = working data[out_index]; out_last=1 when exactly one bit remains. On handshake, clear that bit. On the last handshake: pop, row_done, IDLE.
  - PAR: out_valid=1, out_last=1, out_parallel = data with flag-0 columns forced to 0. Handshake -> pop, row_done, IDLE.
- Latency: rd_start at edge t -> first out_valid after edge t+2. Serial throughput is 1 nonzero per cycle while out_ready=1.
- Outputs hold stable while out_valid&&!out_ready. out_serial, out_index and out_parallel are 0 when out_valid=0.
- A write to the head slot cannot occur while it is being drained (full blocks writes). Data is taken from working registers, so a push during drain is safe.

Optional Feature:
ACT_ROW_BUFFER_REPLAY_EN. When defined, adds input rd_replay (1 bit). On the final handshake with rd_replay=1, the row is not popped; the working mask is restored from the latched flag, the FSM re-enters SER/PAR the next cycle, and row_done does not pulse. This supports kernel-row reuse. When undefined, the port is absent and every final handshake pops.

Decomposition:
- Shared package/header act_buf_pkg: FSM state encoding, IDX_W/occupancy width functions, popcount function.
- One sub-module, lsb_index_enc: a parametrised lowest-set-bit encoder with NUM_COL inputs, producing IDX_W index plus an any-set flag. Purely combinational; used by the SER datapath.

Test Plan:
- Reset then write row flag=16'h8011, data col=i+1; rd_start, mode=0, out_ready=1 -> beats (idx0,1),(idx4,5),(idx15,16,last); row_val_num=3; row_done once; empty=1.
- Same row, mode=1 -> single beat out_parallel with cols 0,4,15 nonzero and others 0, out_last=1.
- Write 4 rows -> wr_ready=0, occupancy=4. Fifth write is ignored. Drain one row -> wr_ready=1. Push during next drain -> occupancy stays 4.
- flag=0 row, mode=0 -> no out_valid; row_done pulse 2 cycles after rd_start; occupancy decrements.
- Serial drain with out_ready toggling 1,0,0,1 -> outputs held while stalled; no beat lost or duplicated.
- reset asserted mid-SER -> out_valid=0 immediately, empty=1; REPLAY_EN build: rd_replay=1 on last -> identical beat sequence repeats, no pop.
